// File: rtl/bit_rev_sched.sv
// rtl/bit_rev_sched.sv - two-requester round-robin scheduler feeding a one-entry bit-transform output register
module bit_rev_sched (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_val,
    output logic       req0_rdy,
    input  logic [7:0] req0_msg,
    input  logic       req1_val,
    output logic       req1_rdy,
    input  logic [7:0] req1_msg,
    input  logic       cfg_val,
    output logic       cfg_rdy,
    input  logic [1:0] cfg_mode,
    output logic       out_val,
    input  logic       out_rdy,
    output logic [7:0] out_msg,
    output logic       out_src,
    output logic [1:0] mode
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic       ptr_q, ptr_d;
    logic [7:0] out_msg_q, out_msg_d;
    logic       out_src_q, out_src_d;

    logic       can_accept;
    logic       cfg_block;
    logic       xfer0, xfer1;
    logic [7:0] sel_msg;

    function automatic logic [7:0] transform(input logic [7:0] d, input logic [1:0] m);
        logic [7:0] r;
        case (m)
            2'd0:    r = {d[0], d[1], d[2], d[3], d[4], d[5], d[6], d[7]};
            2'd1:    r = {d[4], d[5], d[6], d[7], d[0], d[1], d[2], d[3]};
            2'd2:    r = d;
            default: r = {d[3:0], d[7:4]};
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            mode_q    <= 2'd0;
            ptr_q     <= 1'b0;
            out_msg_q <= 8'h00;
            out_src_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            ptr_q     <= ptr_d;
            out_msg_q <= out_msg_d;
            out_src_q <= out_src_d;
        end
    end

    // Each grant term looks only at the other requester's valid, so a ready
    // never depends on its own valid; with neither valid no transfer can occur.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        ptr_d     = ptr_q;
        out_msg_d = out_msg_q;
        out_src_d = out_src_q;

        can_accept = (state_q == EMPTY) || out_rdy;
        cfg_block  = (state_q == EMPTY) && cfg_val;
        cfg_rdy    = !rst && (state_q == EMPTY);
        req0_rdy   = !rst && can_accept && !cfg_block && (!req1_val || !ptr_q);
        req1_rdy   = !rst && can_accept && !cfg_block && (!req0_val ||  ptr_q);

        xfer0   = req0_val && req0_rdy;
        xfer1   = req1_val && req1_rdy;
        sel_msg = xfer1 ? req1_msg : req0_msg;

        if (cfg_val && cfg_rdy)
            mode_d = cfg_mode;

        if (xfer0 || xfer1) begin
            state_d   = FULL;
            out_msg_d = transform(sel_msg, mode_q);
            out_src_d = xfer1;
            ptr_d     = !xfer1;
        end else if ((state_q == FULL) && out_rdy) begin
            state_d = EMPTY;
        end
    end

    assign out_val = (state_q == FULL);
    assign out_msg = out_msg_q;
    assign out_src = out_src_q;
    assign mode    = mode_q;

endmodule
